// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed program image loader for the 8-bit CPU RAM
// Frame: LEN, BASE, LEN data bytes, CSUM; holds the CPU halted while loading.
module prog_loader #(
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_data,
   output logic       ram_wren,
   output logic       cpu_halt,
   output logic       cpu_run,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_BASE, S_DATA, S_CSUM, S_RUN, S_DONE, S_ERR
   } state_t;

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   logic [7:0]    len;
   logic [7:0]    cnt;
   logic [7:0]    acc;
   logic [7:0]    ptr;
   logic [TW-1:0] tmo;
   logic          accept;

   always_comb begin
      in_ready = (state == S_LEN) || (state == S_BASE) ||
                 (state == S_DATA) || (state == S_CSUM);
      accept   = in_ready && in_valid;
   end

   // Status outputs are pure decodes of the state register.
   assign cpu_halt = in_ready;
   assign cpu_run  = (state == S_RUN);
   assign busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         len      <= 8'd0;
         cnt      <= 8'd0;
         acc      <= 8'd0;
         ptr      <= 8'd0;
         tmo      <= '0;
         ram_addr <= 8'd0;
         ram_data <= 8'd0;
         ram_wren <= 1'b0;
      end else begin
         ram_wren <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state <= S_LEN;
                  acc   <= 8'd0;
                  cnt   <= 8'd0;
                  tmo   <= '0;
               end
            end
            S_RUN: state <= S_DONE;
            default: begin
               if (accept) begin
                  tmo <= '0;
                  case (state)
                     S_LEN: begin
                        len   <= in_data;
                        state <= (in_data == 8'd0) ? S_ERR : S_BASE;
                     end
                     S_BASE: begin
                        ptr   <= in_data;
                        state <= S_DATA;
                     end
                     S_DATA: begin
                        ram_wren <= 1'b1;
                        ram_addr <= ptr;
                        ram_data <= in_data;
                        ptr      <= ptr + 8'd1;
                        acc      <= acc + in_data;
                        cnt      <= cnt + 8'd1;
                        if (cnt == len - 8'd1)
                           state <= S_CSUM;
                     end
                     default: state <= (in_data == acc) ? S_RUN : S_ERR;
                  endcase
               end else if (TIMEOUT != 0) begin
                  if (tmo == TMO_LAST)
                     state <= S_ERR;
                  else
                     tmo <= tmo + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
